// File: rtl/am25ls_pkg.sv
// -----------------------------------------------------------------------------
// am25ls_pkg
// Shared definitions for the Am25LS-style counter slices.
//   DIR_UP / DIR_DOWN : values of the ud_ direction input
//   SLICE_W           : width of one counter slice (4 bits)
//   slice_op_e        : operation a slice performs on the next rising edge
//   step_count()      : modulo-2^SLICE_W increment/decrement of one slice
// -----------------------------------------------------------------------------
package am25ls_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int SLICE_W = 4;

    localparam logic [SLICE_W-1:0] SLICE_ZERO = 4'b0000;
    localparam logic [SLICE_W-1:0] SLICE_ONE  = 4'b0001;
    localparam logic [SLICE_W-1:0] SLICE_ONES = 4'b1111;

    // Edge operation, listed in priority order (clear beats load beats count).
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } slice_op_e;

    // One count step; wraps naturally through the fixed slice width.
    function automatic logic [SLICE_W-1:0] step_count(
        input logic [SLICE_W-1:0] value,
        input logic               dir
    );
        logic [SLICE_W-1:0] result;
        if (dir == DIR_UP) begin
            result = value + SLICE_ONE;
        end else begin
            result = value - SLICE_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/am25ls169_slice.sv
// -----------------------------------------------------------------------------
// am25ls169_slice
// One 4-bit synchronous presettable up/down counter slice.
//   cp     : clock, all state changes on the rising edge
//   clr    : synchronous clear, active-high (highest priority)
//   load_  : synchronous parallel load, active-low
//   ud_    : direction, 1 = up, 0 = down
//   enp_   : count enable P, active-low, does not gate rco_
//   ent_   : count enable T, active-low, cascade input, gates rco_
//   din    : parallel load data
//   q      : counter state (registered)
//   rco_   : ripple carry/borrow out, active-low, combinational
// -----------------------------------------------------------------------------
module am25ls169_slice
    import am25ls_pkg::*;
(
    input  logic               cp,
    input  logic               clr,
    input  logic               load_,
    input  logic               ud_,
    input  logic               enp_,
    input  logic               ent_,
    input  logic [SLICE_W-1:0] din,
    output logic [SLICE_W-1:0] q,
    output logic               rco_
);

    slice_op_e          op_s;
    logic [SLICE_W-1:0] q_r;
    logic [SLICE_W-1:0] q_next_s;
    logic               terminal_s;
    logic               rco_s;

    // Decode the edge operation; clr is tested first so unknown enables
    // while clearing cannot leak into the state.
    always_comb begin
        op_s = OP_HOLD;
        if (clr) begin
            op_s = OP_CLEAR;
        end else if (!load_) begin
            op_s = OP_LOAD;
        end else if (!enp_ && !ent_) begin
            op_s = OP_COUNT;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next-state selection for the decoded operation.
    always_comb begin
        q_next_s = q_r;
        case (op_s)
            OP_CLEAR: q_next_s = SLICE_ZERO;
            OP_LOAD:  q_next_s = din;
            OP_COUNT: q_next_s = step_count(q_r, ud_);
            OP_HOLD:  q_next_s = q_r;
            default:  q_next_s = q_r;
        endcase
    end

    // State register; clearing is folded into the next-state logic above.
    always_ff @(posedge cp) begin
        q_r <= q_next_s;
    end

    // Terminal count for the current direction: all ones going up, zero going down.
    always_comb begin
        terminal_s = 1'b0;
        if (ud_ == DIR_UP) begin
            terminal_s = (q_r == SLICE_ONES);
        end else begin
            terminal_s = (q_r == SLICE_ZERO);
        end
    end

    // Carry/borrow out is gated only by ent_, never by enp_, so a chain of
    // slices can hold with enp_ while still presenting a valid cascade.
    always_comb begin
        rco_s = ~(terminal_s & ~ent_);
    end

    assign q    = q_r;
    assign rco_ = rco_s;

endmodule

// File: rtl/am25ls169.sv
// -----------------------------------------------------------------------------
// am25ls169
// WIDTH-bit synchronous presettable up/down binary counter built from
// WIDTH/4 cascaded 4-bit slices with ent_/rco_ ripple chaining.
//   cp     : clock, all state changes on the rising edge
//   clr    : synchronous clear, active-high
//   load_  : synchronous parallel load, active-low
//   ud_    : direction, 1 = up, 0 = down
//   enp_   : count enable P, active-low
//   ent_   : count enable T, active-low, gates rco_
//   din    : parallel load data
//   q      : counter state
//   rco_   : ripple carry/borrow out of the last slice, active-low
// -----------------------------------------------------------------------------
module am25ls169
    import am25ls_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             cp,
    input  logic             clr,
    input  logic             load_,
    input  logic             ud_,
    input  logic             enp_,
    input  logic             ent_,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             rco_
);

    localparam int NUM_SLICES = WIDTH / SLICE_W;

    if (((WIDTH % SLICE_W) != 32'sd0) || (WIDTH < SLICE_W)) begin : g_width_check
        $error("am25ls169: WIDTH must be a non-zero multiple of 4");
    end

    // Each slice counts only when every lower slice sits at its terminal
    // value, which is exactly what its ent_ (the lower rco_) reports. The
    // chain is combinational, so carries and borrows cross all slices in a
    // single clock.
    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        logic ent_in_s;
        logic rco_out_s;

        if (k == 0) begin : g_head
            assign ent_in_s = ent_;
        end else begin : g_tail
            assign ent_in_s = g_slice[k-1].rco_out_s;
        end

        am25ls169_slice u_slice (
            .cp    (cp),
            .clr   (clr),
            .load_ (load_),
            .ud_   (ud_),
            .enp_  (enp_),
            .ent_  (ent_in_s),
            .din   (din[k*SLICE_W +: SLICE_W]),
            .q     (q[k*SLICE_W +: SLICE_W]),
            .rco_  (rco_out_s)
        );
    end

    assign rco_ = g_slice[NUM_SLICES-1].rco_out_s;

endmodule
